csrs_access_ctrl: RTL
=====================

Name: csrs_access_ctrl

Overview:
Upstream sequencer between the execute stage and the CSR banks, including the hypervisor CSR bank. It accepts one Zicsr instruction at a time and reads the old value through the bank's RDEN/RADDR -> RVALID/RDATA read port. It then computes the new value for CSRRW/RS/RC and their immediate forms, issues a single-cycle write, and returns the old value to the pipeline.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles to wait for CSR_RVALID after CSR_RDEN; used only with CSRS_ACC_TIMEOUT_EN.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST  in  1  synchronous, active-low reset.
REQ_VALID  in  1  request from execute stage.
REQ_READY  out  1  block can accept a request; high only in IDLE.
REQ_ADDR  in  12  CSR address.
REQ_FUNCT3  in  3  Zicsr funct3.
REQ_SRC  in  32  rs1 value for register forms.
REQ_ZIMM  in  5  uimm for immediate forms; zero-extended.
REQ_RS1_ZERO  in  1  rs1 field is x0.
REQ_RD_ZERO  in  1  rd field is x0.
RESP_VALID  out  1  response available.
RESP_READY  in  1  pipeline consumes the response.
RESP_DATA  out  32  old CSR value; 0 on exception or when the read is skipped.
RESP_EXC  out  1  illegal-instruction or timeout indication.
CSR_RDEN  out  1  read strobe to the CSR bank.
CSR_RADDR  out  12  read address.
CSR_RVALID  in  1  read data valid.
CSR_RDATA  in  32  read data.
CSR_WREN  out  1  write strobe.
CSR_WADDR  out  12  write address.
CSR_WDATA  out  32  write data.

Behaviour:
- Reset (RST=0 at a clock edge): state IDLE. REQ_READY=1 after reset. RESP_VALID, RESP_EXC, CSR_RDEN and CSR_WREN = 0. RESP_DATA, CSR_RADDR, CSR_WADDR and CSR_WDATA = 0. Reset mid-transaction aborts immediately; no write is issued afterwards.
- Operand select: op = REQ_FUNCT3[2] ? {27'b0, REQ_ZIMM} : REQ_SRC. Address, funct3 and op are latched on accept (REQ_VALID && REQ_READY).
- Read needed: rd_need = !(funct3[1:0]==01 && REQ_RD_ZERO).
- Write needed: wr_need = (funct3[1:0]==01) || (REQ_FUNCT3[2] ? REQ_ZIMM!=0 : !REQ_RS1_ZERO).
- Illegal request: funct3[1:0]==00, or (wr_need && ADDR[11:10]==2'b11). An illegal request goes IDLE -> RESP with RESP_EXC=1 and RESP_DATA=0. No CSR strobe is issued.
- State machine:
  - IDLE: on a legal accept, go to READ if rd_need, else WRITE.
  - READ: CSR_RDEN=1 for exactly one cycle with CSR_RADDR=addr, then go to WAIT.
  - WAIT: hold until CSR_RVALID=1. Latch old=CSR_RDATA, then go to WRITE if wr_need, else RESP.
  - WRITE: CSR_WREN=1 for exactly one cycle with CSR_WADDR=addr and CSR_WDATA=new, then go to RESP.
    - RW: new = op.
    - RS: new = old | op.
    - RC: new = old & ~op.
    - When the read was skipped (RW, rd=x0), old is treated as 0.
  - RESP: RESP_VALID=1 with RESP_DATA=old (0 if the read was skipped). Held stable until RESP_READY=1, then go to IDLE. REQ_READY rises on the next cycle.
- Latency with the bank's 1-cycle RVALID: accept at edge N; CSR_RDEN high N+1; RVALID N+2; CSR_WREN N+3; RESP_VALID N+4. Without a write, RESP_VALID is at N+3.
- CSR_RVALID outside WAIT is ignored.
- At most one outstanding transaction; REQ_READY=0 in every state except IDLE.

Optional Feature:
CSRS_ACC_TIMEOUT_EN
- Defined: WAIT runs a cycle counter that is cleared on entry to WAIT. When the counter reaches TIMEOUT_CYCLES without CSR_RVALID, go to RESP with RESP_EXC=1 and RESP_DATA=0, and skip the write.
- Undefined: no counter; WAIT holds indefinitely.

Test Plan:
1. Reset held low for 3 cycles, then released -> REQ_READY=1; all strobes, RESP_VALID and RESP_EXC = 0.
2. CSRRW (funct3=001), addr=0x600, SRC=0xDEADBEEF, bank returns 0x12345678 -> CSR_WDATA=0xDEADBEEF at N+3; RESP_DATA=0x12345678 at N+4.
3. CSRRSI (funct3=110), ZIMM=0 -> CSR_RDEN pulses once, no CSR_WREN; RESP_DATA equals the bank value.
4. CSRRC (funct3=011) with SRC=0x0000FF00, old=0xFFFFFFFF -> CSR_WDATA=0xFFFF00FF.
5. CSRRW to addr=0xC00 -> RESP_EXC=1 and RESP_DATA=0; no CSR_RDEN or CSR_WREN. Also funct3=100 -> RESP_EXC=1.
6. RESP_READY held low for 5 cycles -> RESP_VALID and RESP_DATA stable; REQ_READY=0 throughout. With CSRS_ACC_TIMEOUT_EN defined and RVALID withheld -> RESP_EXC=1 after 16 WAIT cycles.

Source files
------------

// File: rtl/csrs_access_ctrl.sv
// csrs_access_ctrl: sequencer between the execute stage and the CSR banks.
// It takes one Zicsr instruction at a time. It reads the old CSR value
// through the RDEN/RADDR -> RVALID/RDATA port and computes the new value for
// CSRRW/RS/RC and their immediate forms. It then issues a single-cycle write
// and returns the old value to the pipeline.
// Optional feature macro: CSRS_ACC_TIMEOUT_EN. When it is defined, a read that
// gets no RVALID within TIMEOUT_CYCLES WAIT cycles is answered with RESP_EXC.
module csrs_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [11:0] REQ_ADDR,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_SRC,
  input  logic [4:0]  REQ_ZIMM,
  input  logic        REQ_RS1_ZERO,
  input  logic        REQ_RD_ZERO,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [31:0] RESP_DATA,
  output logic        RESP_EXC,
  output logic        CSR_RDEN,
  output logic [11:0] CSR_RADDR,
  input  logic        CSR_RVALID,
  input  logic [31:0] CSR_RDATA,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        accept;
  logic        rd_need;
  logic        wr_need;
  logic        illegal;
  logic [31:0] op;
  logic        timeout;

  // Latched transaction context. The data registers carry no reset because
  // every output that shows them is gated by the state.
  logic [11:0] addr_q;
  logic [1:0]  kind_q;
  logic [31:0] op_q;
  logic [31:0] old_q;
  logic        wr_need_q;
  logic        exc_q;
  logic [31:0] new_val;

  assign accept  = REQ_VALID && (state == S_IDLE);
  assign op      = REQ_FUNCT3[2] ? {27'b0, REQ_ZIMM} : REQ_SRC;
  assign rd_need = !((REQ_FUNCT3[1:0] == 2'b01) && REQ_RD_ZERO);
  assign wr_need = (REQ_FUNCT3[1:0] == 2'b01) ||
                   (REQ_FUNCT3[2] ? (REQ_ZIMM != 5'd0) : !REQ_RS1_ZERO);
  // Writes to the read-only CSR quadrant (addr[11:10] == 11) are illegal.
  assign illegal = (REQ_FUNCT3[1:0] == 2'b00) ||
                   (wr_need && (REQ_ADDR[11:10] == 2'b11));

`ifdef CSRS_ACC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // The counter only moves in WAIT. The last silent cycle is TIMEOUT_CYCLES-1.
  assign timeout = (state == S_WAIT) && !CSR_RVALID &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter: cleared while in READ, so it is zero on entry to WAIT.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
    end else if (state == S_READ) begin
      cnt <= '0;
    end else if ((state == S_WAIT) && !timeout) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  // State register and exception flag (control, reset synchronously).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
      exc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        exc_q <= illegal;
      end else if (timeout) begin
        exc_q <= 1'b1;
      end
    end
  end

  // Transaction context capture. old_q is cleared on accept, so a skipped
  // read, an illegal request and a timeout all report zero.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q    <= REQ_ADDR;
      kind_q    <= REQ_FUNCT3[1:0];
      op_q      <= op;
      wr_need_q <= wr_need;
      old_q     <= 32'd0;
    end else if ((state == S_WAIT) && CSR_RVALID) begin
      old_q     <= CSR_RDATA;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (illegal)      state_nxt = S_RESP;
          else if (rd_need) state_nxt = S_READ;
          else              state_nxt = S_WRITE;
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (CSR_RVALID)   state_nxt = wr_need_q ? S_WRITE : S_RESP;
        else if (timeout) state_nxt = S_RESP;
      end
      S_WRITE: state_nxt = S_RESP;
      S_RESP: begin
        if (RESP_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // New CSR value from the latched operand and the old value.
  always_comb begin
    case (kind_q)
      2'b10:   new_val = old_q | op_q;
      2'b11:   new_val = old_q & ~op_q;
      default: new_val = op_q;
    endcase
  end

  // Moore outputs. Addresses and data are forced to zero outside their state.
  always_comb begin
    REQ_READY  = (state == S_IDLE);
    CSR_RDEN   = (state == S_READ);
    CSR_RADDR  = (state == S_READ) ? addr_q : 12'd0;
    CSR_WREN   = (state == S_WRITE);
    CSR_WADDR  = (state == S_WRITE) ? addr_q : 12'd0;
    CSR_WDATA  = (state == S_WRITE) ? new_val : 32'd0;
    RESP_VALID = (state == S_RESP);
    RESP_EXC   = (state == S_RESP) && exc_q;
    RESP_DATA  = ((state == S_RESP) && !exc_q) ? old_q : 32'd0;
  end

endmodule
